// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per clock through one
// adder slice with a registered carry, start/ready/done handshake and status flags.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             mode,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic             creg;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] wsum;

  logic [CHUNK-1:0] achunk;
  logic [CHUNK-1:0] bchunk;
  logic [CW-1:0]    slice;
  logic [WIDTH-1:0] nsum;
  logic             cmsb;
  logic             last;

  always_comb begin
    achunk = areg[int'(idx) * CHUNK +: CHUNK];
    bchunk = breg[int'(idx) * CHUNK +: CHUNK];
    slice  = {1'b0, achunk} + {1'b0, bchunk} + CW'(creg);
    // carry into the slice MSB recovered from sum = a ^ b ^ cin; also covers CHUNK = 1
    cmsb   = slice[CHUNK-1] ^ achunk[CHUNK-1] ^ bchunk[CHUNK-1];
    nsum   = wsum;
    nsum[int'(idx) * CHUNK +: CHUNK] = slice[CHUNK-1:0];
    last   = (idx == IW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      idx      <= '0;
      creg     <= 1'b0;
      areg     <= '0;
      breg     <= '0;
      wsum     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= inputA;
            breg  <= inputB ^ {WIDTH{mode}};
            creg  <= mode;
            idx   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          wsum <= nsum;
          creg <= slice[CHUNK];
          idx  <= idx + IW'(1);
          if (last) begin
            sum      <= nsum;
            carry    <= slice[CHUNK];
            overflow <= slice[CHUNK] ^ cmsb;
            zero     <= (nsum == '0);
            negative <= nsum[WIDTH-1];
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: a 16/4 instance for timing, flags, ignored starts
// and reset abort, plus a 4/4 instance for the single-chunk case.
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start16 = 1'b0, m16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, done16, c16, v16, z16, n16;
  logic [15:0] sum16;

  logic        start4 = 1'b0, m4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, done4, c4, v4, z4, n4;
  logic [3:0]  sum4;

  int total = 0;
  int bad = 0;
  logic [15:0] prev = '0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .inputA(a16), .inputB(b16), .mode(m16),
    .ready(ready16), .done(done16), .sum(sum16), .carry(c16), .overflow(v16),
    .zero(z16), .negative(n16)
  );

  addsub_seq #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .inputA(a4), .inputB(b4), .mode(m4),
    .ready(ready4), .done(done4), .sum(sum4), .carry(c4), .overflow(v4),
    .zero(z4), .negative(n4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start accepted at edge 0; done expected exactly at edge 4, ready back at edge 5
  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic [15:0] es, input logic ec,
                       input logic ev, input logic ez, input logic en);
    a16 = a; b16 = b; m16 = m; start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk({tag, ".busy"}, {31'd0, ready16}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) begin
        chk({tag, ".nodone"}, {31'd0, done16}, 32'd0);
        chk({tag, ".hold"}, {16'd0, sum16}, {16'd0, prev});
      end
    end
    chk({tag, ".done"}, {31'd0, done16}, 32'd1);
    chk({tag, ".sum"}, {16'd0, sum16}, {16'd0, es});
    chk({tag, ".flags"}, {28'd0, c16, v16, z16, n16}, {28'd0, ec, ev, ez, en});
    step();
    chk({tag, ".ready"}, {30'd0, ready16, done16}, 32'd2);
    prev = es;
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    chk("rst.ctl16", {30'd0, ready16, done16}, 32'd2);
    chk("rst.out16", {12'd0, sum16, c16, v16, z16, n16}, 32'd0);
    chk("rst.ctl4", {30'd0, ready4, done4}, 32'd2);
    reset = 1'b0;
    step();

    run16("add1", 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0, 1'b0);
    run16("addwrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run16("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run16("subneg", 16'h0004, 16'h0005, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run16("subeq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run16("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // reset at edge 2 of a run, then reset together with start
    a16 = 16'h1234; b16 = 16'h0FF0; m16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    step();
    reset = 1'b1; start16 = 1'b1;
    step();
    chk("abort.ctl", {30'd0, ready16, done16}, 32'd2);
    chk("abort.out", {12'd0, sum16, c16, v16, z16, n16}, 32'd0);
    step();
    reset = 1'b0; start16 = 1'b0;
    step();
    chk("rststart.idle", {30'd0, ready16, done16}, 32'd2);
    step();
    step();
    chk("abort.nodone", {31'd0, done16}, 32'd0);
    prev = 16'h0000;
    run16("postrst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // stray starts during RUN and DONE, operand change mid-run
    a16 = 16'h0001; b16 = 16'h0001; m16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    a16 = 16'h1111;
    step();
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    m16 = 1'b1;
    step();
    chk("ign.nodone", {31'd0, done16}, 32'd0);
    step();
    chk("ign.done", {31'd0, done16}, 32'd1);
    chk("ign.sum", {16'd0, sum16}, 32'h0002);
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("ign.ready", {30'd0, ready16, done16}, 32'd2);
    step();
    chk("ign.notqueued", {30'd0, ready16, done16}, 32'd2);
    step();
    chk("ign.sumheld", {16'd0, sum16}, 32'h0002);

    // single-chunk instance
    a4 = 4'b0100; b4 = 4'b0101; m4 = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("w4.busy", {31'd0, ready4}, 32'd0);
    step();
    chk("w4.done", {31'd0, done4}, 32'd1);
    chk("w4.sum", {28'd0, sum4}, 32'hF);
    chk("w4.flags", {28'd0, c4, v4, z4, n4}, 32'b0001);
    step();
    chk("w4.ready", {30'd0, ready4, done4}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
